// File: rtl/puf_eval_sequencer.sv
// Arbiter-PUF evaluation sequencer: repeats clear/launch/settle/sample VOTES times
// on a latched challenge and publishes a majority-voted response with a stability flag.
module puf_eval_sequencer #(
  parameter int CHAL_W        = 64,
  parameter int SETTLE_CYCLES = 16,
  parameter int VOTES         = 7,
  parameter int CNT_W         = $clog2(VOTES + 1)
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              start,
  input  logic [CHAL_W-1:0] challenge_in,
  output logic              busy,
  output logic              done,
  output logic              response,
  output logic [CNT_W-1:0]  ones_count,
  output logic              stable,
  output logic [CHAL_W-1:0] puf_challenge,
  output logic              puf_clear,
  output logic              puf_launch,
  input  logic              puf_resp
);

  localparam int SET_W = $clog2(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 3) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 3");
  end
  if ((VOTES == 0) || (VOTES % 2 == 0)) begin : g_bad_votes
    $error("VOTES must be odd and non-zero");
  end

  typedef enum logic [2:0] {
    IDLE, CLEAR, LAUNCH, SETTLE, SAMPLE, DONE
  } state_t;

  state_t state, state_next;

  logic [CHAL_W-1:0] chal_q;
  logic [SET_W-1:0]  settle_cnt;
  logic [CNT_W-1:0]  acc;
  logic [CNT_W-1:0]  vote;
  logic [CNT_W-1:0]  acc_sum;
  logic              sync_meta;
  logic              resp_s;
  logic              last_vote;

  assign acc_sum       = acc + {{(CNT_W-1){1'b0}}, resp_s};
  assign last_vote     = (vote == CNT_W'(VOTES - 1));
  assign puf_challenge = chal_q;

  // puf_resp races asynchronously to ACLK, so only the second flop is ever used
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      sync_meta <= 1'b0;
      resp_s    <= 1'b0;
    end else begin
      sync_meta <= puf_resp;
      resp_s    <= sync_meta;
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = (state != IDLE);
    puf_clear  = 1'b0;
    puf_launch = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:   if (start) state_next = CLEAR;
      CLEAR:  begin
        puf_clear  = 1'b1;
        state_next = LAUNCH;
      end
      LAUNCH: begin
        puf_launch = 1'b1;
        state_next = SETTLE;
      end
      SETTLE: if (settle_cnt == '0) state_next = SAMPLE;
      SAMPLE: state_next = last_vote ? DONE : CLEAR;
      DONE:   begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Results are captured on the final sample so they are already valid while done is high
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      chal_q     <= '0;
      settle_cnt <= '0;
      acc        <= '0;
      vote       <= '0;
      ones_count <= '0;
      response   <= 1'b0;
      stable     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          chal_q <= challenge_in;
          acc    <= '0;
          vote   <= '0;
        end
        LAUNCH: settle_cnt <= SET_W'(SETTLE_CYCLES - 1);
        SETTLE: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        SAMPLE: begin
          acc  <= acc_sum;
          vote <= vote + 1'b1;
          if (last_vote) begin
            ones_count <= acc_sum;
            response   <= (acc_sum > CNT_W'(VOTES / 2));
            stable     <= (acc_sum == '0) || (acc_sum == CNT_W'(VOTES));
          end
        end
        default: ;
      endcase
    end
  end

endmodule
